// File: rtl/spn_round_engine.sv
// rtl/spn_round_engine.sv - iterative 16-bit SPN block cipher, one S-box nibble per cycle
//
// s_box: 4-bit substitution table.
//   nib_i  in   4  nibble to substitute
//   nib_o  out  4  substituted nibble
//
// spn_round_engine: ROUNDS full rounds of add-key / substitute / permute,
// followed by a final key whitening step.
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous active-low reset
//   start     in   1   encrypt request, sampled only in IDLE
//   data_in   in   16  plaintext block (nibble k = bits [4k+3:4k])
//   key       in   16  cipher key
//   busy      out  1   high in ADD, SUB, PERM and FINAL
//   done      out  1   one-cycle pulse, data_out valid
//   data_out  out  16  ciphertext, held until the next done
// ROUNDS must lie in 1..15 so that r and rk(ROUNDS) fit in 4 bits.

module s_box (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  always_comb begin
    nib_o = 4'h0;
    case (nib_i)
      4'h0: nib_o = 4'h9;
      4'h1: nib_o = 4'h4;
      4'h2: nib_o = 4'hA;
      4'h3: nib_o = 4'hB;
      4'h4: nib_o = 4'hD;
      4'h5: nib_o = 4'h1;
      4'h6: nib_o = 4'h8;
      4'h7: nib_o = 4'h5;
      4'h8: nib_o = 4'h6;
      4'h9: nib_o = 4'h2;
      4'hA: nib_o = 4'h0;
      4'hB: nib_o = 4'h3;
      4'hC: nib_o = 4'hC;
      4'hD: nib_o = 4'hE;
      4'hE: nib_o = 4'hF;
      4'hF: nib_o = 4'h7;
      default: nib_o = 4'h0;
    endcase
  end
endmodule

module spn_round_engine #(
  parameter int unsigned ROUNDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] data_in,
  input  logic [15:0] key,
  output logic        busy,
  output logic        done,
  output logic [15:0] data_out
);
  typedef enum logic [2:0] {IDLE, ADD, SUB, PERM, FINAL, DONE} fsm_t;

  localparam logic [3:0] LAST_R = 4'(ROUNDS - 1);
  localparam logic [3:0] NUM_R  = 4'(ROUNDS);

  fsm_t        fsm_q;
  logic [15:0] state_q;
  logic [15:0] key_q;
  logic [3:0]  r_q;
  logic [1:0]  n_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] dout_q;

  logic [15:0] rk;
  logic [3:0]  sub_in;
  logic [3:0]  sub_out;
  logic [15:0] perm;

  assign rk     = key_q ^ {12'h000, r_q};
  assign sub_in = state_q[{n_q, 2'b00} +: 4];

  s_box u_s_box (
    .nib_i (sub_in),
    .nib_o (sub_out)
  );

  // Bit i moves to (4*i) mod 15; bit 15 stays put.
  always_comb begin
    perm = 16'h0000;
    for (int i = 0; i < 15; i++) begin
      perm[(4 * i) % 15] = state_q[i];
    end
    perm[15] = state_q[15];
  end

  // busy and done are written alongside each transition so they reflect
  // the state being entered, keeping them registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= 16'h0000;
      key_q   <= 16'h0000;
      r_q     <= 4'h0;
      n_q     <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= 16'h0000;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (start) begin
            state_q <= data_in;
            key_q   <= key;
            r_q     <= 4'h0;
            n_q     <= 2'd0;
            busy_q  <= 1'b1;
            fsm_q   <= ADD;
          end
        end
        ADD: begin
          state_q <= state_q ^ rk;
          n_q     <= 2'd0;
          fsm_q   <= SUB;
        end
        SUB: begin
          state_q[{n_q, 2'b00} +: 4] <= sub_out;
          if (n_q == 2'd3) begin
            n_q   <= 2'd0;
            fsm_q <= PERM;
          end else begin
            n_q <= n_q + 2'd1;
          end
        end
        PERM: begin
          state_q <= perm;
          if (r_q < LAST_R) begin
            r_q   <= r_q + 4'h1;
            fsm_q <= ADD;
          end else begin
            r_q   <= NUM_R;
            fsm_q <= FINAL;
          end
        end
        FINAL: begin
          dout_q <= state_q ^ rk;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          fsm_q  <= DONE;
        end
        DONE: begin
          fsm_q <= IDLE;
        end
        default: begin
          fsm_q  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = dout_q;
endmodule

// File: tb/tb_spn_round_engine.sv
// tb/tb_spn_round_engine.sv - randomized model-checked bench for spn_round_engine at ROUNDS 1, 4, 15
module tb_spn_round_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [3];
  logic        start  [3];
  logic [15:0] din    [3];
  logic [15:0] kin    [3];
  logic        busy_w [3];
  logic        done_w [3];
  logic [15:0] dout_w [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    spn_round_engine #(.ROUNDS((g == 0) ? 1 : ((g == 1) ? 4 : 15))) u_dut (
      .clk      (clk),
      .rst_n    (rst_n[g]),
      .start    (start[g]),
      .data_in  (din[g]),
      .key      (kin[g]),
      .busy     (busy_w[g]),
      .done     (done_w[g]),
      .data_out (dout_w[g])
    );
  end

  int rv [3] = '{1, 4, 15};
  logic [3:0] sbox_t [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                              4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] sub16(input logic [15:0] s);
    logic [15:0] o;
    for (int k = 0; k < 4; k++) o[4*k +: 4] = sbox_t[s[4*k +: 4]];
    return o;
  endfunction

  function automatic logic [15:0] perm16(input logic [15:0] s);
    logic [15:0] o;
    o = 16'h0;
    for (int i = 0; i < 16; i++) o[(i == 15) ? 15 : (4 * i) % 15] = s[i];
    return o;
  endfunction

  function automatic logic [15:0] enc(input logic [15:0] p, input logic [15:0] k, input int nr);
    logic [15:0] s;
    s = p;
    for (int r = 0; r < nr; r++) begin
      s = s ^ k ^ 16'(r);
      s = perm16(sub16(s));
    end
    return s ^ k ^ 16'(nr);
  endfunction

  // Reference timing: the accepting edge opens cycle d=0; busy spans d=0..6R,
  // done at d=6R+1, and the edge at d=6R+2 (leaving DONE) cannot accept.
  bit          active  [3];
  int          c0      [3];
  logic [15:0] pend    [3];
  logic [15:0] exp_out [3];
  logic        exp_busy[3];
  logic        exp_done[3];

  initial begin
    for (int g = 0; g < 3; g++) begin
      active[g] = 0; c0[g] = 0; pend[g] = 0; exp_out[g] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int g = 0; g < 3; g++) begin
        if (!rst_n[g]) begin
          active[g]  = 0;
          exp_out[g] = 16'h0;
        end else if (active[g]) begin
          if (cyc - c0[g] == 6 * rv[g] + 2) active[g] = 0;
        end else if (start[g]) begin
          active[g] = 1;
          c0[g]     = cyc;
          pend[g]   = enc(din[g], kin[g], rv[g]);
        end
        exp_busy[g] = active[g] && (cyc - c0[g] <= 6 * rv[g]);
        exp_done[g] = active[g] && (cyc - c0[g] == 6 * rv[g] + 1);
        if (exp_done[g]) exp_out[g] = pend[g];
      end
      #2;
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("busy[R=%0d]", rv[g]), 32'(busy_w[g]), 32'(exp_busy[g]));
        chk($sformatf("done[R=%0d]", rv[g]), 32'(done_w[g]), 32'(exp_done[g]));
        chk($sformatf("data_out[R=%0d]", rv[g]), 32'(dout_w[g]), 32'(exp_out[g]));
      end
    end
  end

  task automatic rand_drive(input int g, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      start[g] = ($urandom_range(0, 3) != 0);
      din[g]   = 16'($urandom);
      kin[g]   = 16'($urandom);
    end
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  initial begin
    int lat;
    int last;
    int cnt;
    for (int g = 0; g < 3; g++) begin
      rst_n[g] = 1'b0; start[g] = 1'b0; din[g] = 16'h0; kin[g] = 16'h0;
    end

    // Hand-computed answers pin the reference model itself.
    chk("model_sub", 32'(sub16(16'h0000)), 32'h9999);
    chk("model_perm", 32'(perm16(16'h9999)), 32'hF00F);
    chk("model_kat", 32'(enc(16'h0000, 16'h0000, 1)), 32'hF00E);
    chk("model_perm_b1", 32'(perm16(16'h0002)), 32'h0010);

    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) rst_n[g] = 1'b1;
    // Reset release: accepted on the very first edge with rst_n high.

    // Known answer at ROUNDS=1.
    start[0] = 1'b1; din[0] = 16'h0000; kin[0] = 16'h0000;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start[0] = 1'b0; din[0] = 16'hFFFF; kin[0] = 16'hA5A5;
      end
      if (done_w[0]) begin
        lat = k;
        break;
      end
    end
    chk("kat_latency", 32'(lat), 32'd8);
    chk("kat_data_out", 32'(dout_w[0]), 32'hF00E);

    // Back-to-back with start held high at ROUNDS=4.
    start[1] = 1'b1; din[1] = 16'h1234; kin[1] = 16'hBEEF;
    last = 0; cnt = 0;
    for (int k = 0; k < 200 && cnt < 3; k++) begin
      @(negedge clk);
      din[1] = 16'($urandom); kin[1] = 16'($urandom);
      if (done_w[1]) begin
        if (cnt > 0) chk("b2b_spacing", 32'(cyc - last), 32'd27);
        last = cyc;
        cnt++;
      end
    end
    chk("b2b_pulses", 32'(cnt), 32'd3);
    start[1] = 1'b0;
    repeat (2) @(negedge clk);

    // Mid-operation reset during SUB of round 2 (d=14), ROUNDS=4.
    start[1] = 1'b1; din[1] = 16'hC0DE; kin[1] = 16'h7777;
    @(posedge clk);
    repeat (14) @(posedge clk);
    @(negedge clk);
    start[1] = 1'b0;
    chk("pre_reset_busy", 32'(busy_w[1]), 32'd1);
    rst_n[1] = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy_w[1]), 32'd0);
    chk("async_rst_done", 32'(done_w[1]), 32'd0);
    chk("async_rst_data_out", 32'(dout_w[1]), 32'h0);
    repeat (3) @(negedge clk);
    rst_n[1] = 1'b1;
    start[1] = 1'b1; din[1] = 16'h5A5A; kin[1] = 16'h0F0F;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_reset_data_out", 32'(dout_w[1]), 32'(enc(16'h5A5A, 16'h0F0F, 4)));

    // Random sweep on all three configurations in parallel.
    fork
      rand_drive(0, 30000);
      rand_drive(1, 30000);
      rand_drive(2, 30000);
    join
    repeat (100) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
